// File: rtl/btn_conditioner.sv
// Three-channel button conditioner: 2-flop synchroniser plus independent debounce per bit.
// Optional one-cycle press pulses on b_press when BTN_PRESS_EN is defined.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:1] btn_raw,
    output logic [3:1] b
`ifdef BTN_PRESS_EN
    ,
    output logic [3:1] b_press
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_e;

    logic [3:1]       sync1;
    logic [3:1]       sync2;
    state_e           state_q [3:1];
    state_e           state_d [3:1];
    logic [CNT_W-1:0] cnt_q   [3:1];
    logic [CNT_W-1:0] cnt_d   [3:1];
    logic [3:1]       b_d;

    // State registers; reset overrides every other update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            b     <= 3'b000;
            for (int i = 1; i <= 3; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            b     <= b_d;
            for (int i = 1; i <= 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Per-channel debounce: any return to the current level restarts the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b;
        for (int i = 1; i <= 3; i++) begin
            case (state_q[i])
                STABLE: begin
                    if (sync2[i] != b[i]) begin
                        if (SINGLE_SAMPLE) begin
                            b_d[i] = sync2[i];
                        end else begin
                            cnt_d[i]   = CNT_W'(1);
                            state_d[i] = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (sync2[i] == b[i]) begin
                        cnt_d[i]   = '0;
                        state_d[i] = STABLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        b_d[i]     = sync2[i];
                        cnt_d[i]   = '0;
                        state_d[i] = STABLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef BTN_PRESS_EN
    // Pulse aligns with the first cycle b is high; releases produce nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_press <= 3'b000;
        end else begin
            b_press <= b_d & ~b;
        end
    end
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=4; directed vectors.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:1] btn_raw;
    logic [3:1] b;
`ifdef BTN_PRESS_EN
    logic [3:1] b_press;
`endif

    typedef struct {
        logic [3:1] b;
        logic [3:1] press;
        string      name;
    } exp_t;

    exp_t       exp_q [$];
    int         checks = 0;
    int         errors = 0;
    logic [3:1] prev_b = 3'b000;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .b      (b)
`ifdef BTN_PRESS_EN
        ,
        .b_press(b_press)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: every falling edge, pop the expectation for the preceding rising edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (b !== e.b) begin
                    errors++;
                    $display("FAIL %s: b=%b expected %b at %0t", e.name, b, e.b, $time);
                end
`ifdef BTN_PRESS_EN
                checks++;
                if (b_press !== e.press) begin
                    errors++;
                    $display("FAIL %s_press: b_press=%b expected %b at %0t",
                             e.name, b_press, e.press, $time);
                end
`endif
            end
        end
    endtask

    // Drive one cycle of inputs and queue the b value expected after the edge.
    task automatic steps(input int n, input logic [3:1] raw, input logic r,
                         input logic [3:1] eb, input string nm);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            btn_raw = raw;
            rst     = r;
            @(posedge clk);
            #1;
            e.b     = eb;
            e.press = r ? 3'b000 : (eb & ~prev_b);
            e.name  = nm;
            prev_b  = eb;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        btn_raw = 3'b000;
        rst     = 1'b1;
        fork
            monitor();
        join_none

        // Reset with all buttons held, then full latency after release.
        steps(2, 3'b111, 1'b1, 3'b000, "rst_hold");
        steps(5, 3'b111, 1'b0, 3'b000, "rst_release_wait");
        steps(1, 3'b111, 1'b0, 3'b111, "rst_release_rise");
        steps(2, 3'b111, 1'b0, 3'b111, "all_hold");

        // Single channel press.
        steps(2, 3'b000, 1'b1, 3'b000, "reset");
        steps(5, 3'b001, 1'b0, 3'b000, "b1_wait");
        steps(1, 3'b001, 1'b0, 3'b001, "b1_rise");
        steps(3, 3'b001, 1'b0, 3'b001, "b1_hold");

        // Bounce on channel 2 restarts the count.
        steps(2, 3'b000, 1'b1, 3'b000, "reset");
        steps(3, 3'b010, 1'b0, 3'b000, "bounce_hi");
        steps(1, 3'b000, 1'b0, 3'b000, "bounce_glitch");
        steps(5, 3'b010, 1'b0, 3'b000, "bounce_recount");
        steps(1, 3'b010, 1'b0, 3'b010, "bounce_rise");
        steps(2, 3'b010, 1'b0, 3'b010, "bounce_hold");

        // Simultaneous press on 3 and 1, then release of 3 only.
        steps(2, 3'b000, 1'b1, 3'b000, "reset");
        steps(5, 3'b101, 1'b0, 3'b000, "pair_wait");
        steps(1, 3'b101, 1'b0, 3'b101, "pair_rise");
        steps(2, 3'b101, 1'b0, 3'b101, "pair_hold");
        steps(5, 3'b001, 1'b0, 3'b101, "b3_release_wait");
        steps(1, 3'b001, 1'b0, 3'b001, "b3_release");
        steps(2, 3'b001, 1'b0, 3'b001, "b3_release_hold");

        // Reset while channel 1 is pending with cnt=2.
        steps(2, 3'b000, 1'b1, 3'b000, "reset");
        steps(4, 3'b001, 1'b0, 3'b000, "pending");
        steps(1, 3'b001, 1'b1, 3'b000, "mid_pending_rst");
        steps(5, 3'b001, 1'b0, 3'b000, "post_rst_wait");
        steps(1, 3'b001, 1'b0, 3'b001, "post_rst_rise");
        steps(1, 3'b001, 1'b0, 3'b001, "post_rst_hold");

        // Release is debounced with the same latency.
        steps(5, 3'b000, 1'b0, 3'b001, "release_wait");
        steps(1, 3'b000, 1'b0, 3'b000, "release_fall");
        steps(2, 3'b000, 1'b0, 3'b000, "idle");

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
